// File: rtl/mem_array_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_array_if: request/response bundle for the mem_array scratch   |
// | memory; pinj/perr exist only when MEM_PARITY_EN is defined.       |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
interface mem_array_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             clr;
    logic             sel;
    logic             op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] inp;
    logic [WIDTH-1:0] outp;
    logic             done;
    logic             busy;
`ifdef MEM_PARITY_EN
    logic             pinj;
    logic             perr;

    modport master (
        output clr, sel, op, addr, inp, pinj,
        input  outp, done, busy, perr
    );
    modport slave (
        input  clr, sel, op, addr, inp, pinj,
        output outp, done, busy, perr
    );
`else
    modport master (
        output clr, sel, op, addr, inp,
        input  outp, done, busy
    );
    modport slave (
        input  clr, sel, op, addr, inp,
        output outp, done, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_array: DEPTH x WIDTH single-port word memory with registered  |
// | read, one-cycle done pulse and a self-clearing sweep FSM.         |
// | Optional even-parity storage/check enabled by MEM_PARITY_EN.      |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module mem_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_array_if.slave  bus
);

`ifdef MEM_PARITY_EN
    localparam int c_pw = 1;
`else
    localparam int c_pw = 0;
`endif
    localparam int            c_mw   = WIDTH + c_pw;
    localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    cptr_q;
    logic             hold_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] outp_q;
    logic [c_mw-1:0]  mem_q [DEPTH];

    logic             w_in_range;
    logic             w_acc;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [c_mw-1:0]  w_mem_wdata;
    logic [c_mw-1:0]  w_rd_word;

    assign w_in_range = ({1'b0, bus.addr} < (AW + 1)'(DEPTH));
    assign w_acc      = (state_q == ST_IDLE) && !bus.clr && bus.sel;
    assign w_rd_word  = w_in_range ? mem_q[bus.addr] : '0;

    // A clear request costs one idle transition cycle before the sweep begins.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = cptr_q;
        w_mem_wdata = '0;
        if (state_q == ST_CLEAR) begin
            w_mem_we = !bus.clr && !hold_q;
        end else if (w_acc && bus.op && w_in_range) begin
            w_mem_we   = 1'b1;
            w_mem_addr = bus.addr;
`ifdef MEM_PARITY_EN
            w_mem_wdata = {(^bus.inp) ^ bus.pinj, bus.inp};
`else
            w_mem_wdata = bus.inp;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_addr] <= w_mem_wdata;
        end
    end

`ifdef MEM_PARITY_EN
    logic perr_q;
    logic w_rd_perr;

    // Stored bit is even parity of the data, so a good word XORs to zero.
    assign w_rd_perr = ^w_rd_word;
    assign bus.perr  = perr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cptr_q  <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            outp_q  <= '0;
`ifdef MEM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MEM_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (state_q == ST_CLEAR) begin
                if (bus.clr) begin
                    cptr_q <= '0;
                    hold_q <= 1'b1;
                    busy_q <= 1'b1;
                end else if (hold_q) begin
                    hold_q <= 1'b0;
                end else if (cptr_q == c_last) begin
                    state_q <= ST_IDLE;
                    cptr_q  <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    cptr_q <= cptr_q + 1'b1;
                end
            end else begin
                if (bus.clr) begin
                    state_q <= ST_CLEAR;
                    cptr_q  <= '0;
                    hold_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end else if (bus.sel) begin
                    done_q <= 1'b1;
                    if (!bus.op) begin
                        outp_q <= w_rd_word[WIDTH-1:0];
`ifdef MEM_PARITY_EN
                        perr_q <= w_rd_perr;
`endif
                    end
                end
            end
        end
    end

    assign bus.outp = outp_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule
`default_nettype wire
